// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped down-counting timer:
// FSM state encodings, register word offsets and CTRL bit positions.
package timer_counter_pkg;

    // FSM state encodings (2-bit)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_INT  = 2'd3;

    // Register word offsets, decoded from Addr[3:2]
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    // CTRL register layout
    localparam int CTRL_W       = 4;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    // MODE encodings: only 01 reloads, everything else behaves as one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_AUTO    = 2'b01;

    function automatic logic is_auto_reload(input logic [1:0] mode);
        return (mode == MODE_AUTO);
    endfunction

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes and a
// maskable interrupt. Three registers (CTRL, PRESET, COUNT) on word offsets
// Addr[3:2]; the address-hit qualification of WE is done outside this block.
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    logic [1:0]        r_state;
    logic [1:0]        w_state;
    logic [CTRL_W-1:0] r_ctrl;
    logic [CTRL_W-1:0] w_ctrl;
    logic [CNT_W-1:0]  r_preset;
    logic [CNT_W-1:0]  w_preset;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count;
    logic              r_irq_flag;
    logic              w_irq_flag;

    logic [1:0]        w_off;
    logic              w_wr_ctrl;
    logic              w_wr_preset;
    logic              w_unused_addr;

    assign w_off         = Addr[3:2];
    assign w_wr_ctrl     = WE && (w_off == OFF_CTRL);
    assign w_wr_preset   = WE && (w_off == OFF_PRESET);
    // Only the word offset is decoded; the remaining address bits are ignored.
    assign w_unused_addr = ^{Addr[29:4], Addr[1:0]};

    // Next-state logic: FSM update first, then bus writes override (bus wins on CTRL.EN)
    always_comb begin
        w_state    = r_state;
        w_ctrl     = r_ctrl;
        w_preset   = r_preset;
        w_count    = r_count;
        w_irq_flag = r_irq_flag;

        case (r_state)
            ST_IDLE: begin
                if (r_ctrl[CTRL_EN]) begin
                    w_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_count    = r_preset;
                w_irq_flag = 1'b0;
                w_state    = ST_CNT;
            end
            ST_CNT: begin
                if (!r_ctrl[CTRL_EN]) begin
                    w_state = ST_IDLE;
                end else if (r_count > CNT_W'(1)) begin
                    w_count = r_count - CNT_W'(1);
                end else begin
                    // PRESET of 0 or 1 both land here, so COUNT never wraps
                    w_count    = '0;
                    w_irq_flag = 1'b1;
                    w_state    = ST_INT;
                end
            end
            ST_INT: begin
                if (is_auto_reload(r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO])) begin
                    // EN stays set, so IDLE relaunches: IRQ is a one-cycle pulse
                    w_irq_flag = 1'b0;
                end else begin
                    w_ctrl[CTRL_EN] = 1'b0;
                end
                w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase

        // Any write to CTRL or PRESET acknowledges a pending interrupt
        if (w_wr_ctrl) begin
            w_ctrl     = Din[CTRL_W-1:0];
            w_irq_flag = 1'b0;
        end
        if (w_wr_preset) begin
            w_preset   = Din[CNT_W-1:0];
            w_irq_flag = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_ctrl     <= '0;
            r_preset   <= '0;
            r_count    <= '0;
            r_irq_flag <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_ctrl     <= w_ctrl;
            r_preset   <= w_preset;
            r_count    <= w_count;
            r_irq_flag <= w_irq_flag;
        end
    end

    // Combinational read mux; narrower registers are zero-extended
    always_comb begin
        case (w_off)
            OFF_CTRL:   Dout = 32'(r_ctrl);
            OFF_PRESET: Dout = 32'(r_preset);
            OFF_COUNT:  Dout = 32'(r_count);
            default:    Dout = 32'd0;
        endcase
    end

    assign IRQ = r_ctrl[CTRL_IM] & r_irq_flag;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus randomized
// bus traffic, checked against a cycle-level reference model through a
// scoreboard queue drained by an independent monitor.
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    always #5 clk = ~clk;

    timer_counter #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    typedef struct {
        logic [31:0] dout;
        logic        irq;
        int          id;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   txn      = 0;

    // ---------------- reference model ----------------
    // Timer activity described by where the timer is in its run:
    // stopped, about to latch PRESET, counting down, or just expired.
    localparam int PH_STOPPED = 0;
    localparam int PH_ARMING  = 1;
    localparam int PH_COUNTING = 2;
    localparam int PH_EXPIRED = 3;

    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_flag;
    int          m_phase;

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input logic rst, input logic we, input logic [1:0] a, input logic [31:0] d);
        logic [3:0]  n_ctrl;
        logic [31:0] n_preset;
        logic [31:0] n_count;
        logic        n_flag;
        int          n_phase;
        if (rst) begin
            m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_flag = 1'b0; m_phase = PH_STOPPED;
            return;
        end
        n_ctrl = m_ctrl; n_preset = m_preset; n_count = m_count; n_flag = m_flag; n_phase = m_phase;
        if (m_phase == PH_STOPPED) begin
            if (m_ctrl[0]) n_phase = PH_ARMING;
        end else if (m_phase == PH_ARMING) begin
            n_count = m_preset; n_flag = 1'b0; n_phase = PH_COUNTING;
        end else if (m_phase == PH_COUNTING) begin
            if (!m_ctrl[0]) n_phase = PH_STOPPED;
            else if (m_count >= 32'd2) n_count = m_count - 32'd1;
            else begin n_count = 32'd0; n_flag = 1'b1; n_phase = PH_EXPIRED; end
        end else begin
            if (m_ctrl[2:1] == 2'b01) n_flag = 1'b0;
            else n_ctrl[0] = 1'b0;
            n_phase = PH_STOPPED;
        end
        if (we && a == 2'd0) begin n_ctrl = d[3:0]; n_flag = 1'b0; end
        if (we && a == 2'd1) begin n_preset = d; n_flag = 1'b0; end
        m_ctrl = n_ctrl; m_preset = n_preset; m_count = n_count; m_flag = n_flag; m_phase = n_phase;
    endtask

    // ---------------- driver: one bus cycle ----------------
    task automatic cycle(input logic rst, input logic we, input logic [1:0] a, input logic [31:0] d);
        exp_t        e;
        logic [29:0] ad;
        ad       = 30'($urandom);
        ad[3:2]  = a;
        reset    = rst;
        WE       = we;
        Addr     = ad;
        Din      = d;
        e.dout   = m_read(a);
        e.irq    = m_ctrl[3] & m_flag;
        e.id     = txn;
        txn++;
        sb_q.push_back(e);
        @(posedge clk);
        model_step(rst, we, a, d);
        #1;
    endtask

    task automatic idle_reads(input int n, input logic [1:0] a);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, a, 32'd0);
    endtask

    // Counts clock edges until the DUT raises IRQ, bounded by budget
    task automatic wait_irq(input int budget, input int exp_n, input string name);
        int n;
        n = 0;
        while (IRQ !== 1'b1 && n < budget) begin
            cycle(1'b0, 1'b0, 2'd2, 32'd0);
            n++;
        end
        checks++;
        if (n != exp_n) begin
            failures++;
            $display("FAIL %s: irq after %0d edges, expected %0d", name, n, exp_n);
        end else begin
            $display("%s: irq after %0d edges ok", name, n);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (Dout !== e.dout || IRQ !== e.irq) begin
                    failures++;
                    $display("FAIL txn%0d: dout=%h irq=%b expected dout=%h irq=%b",
                             e.id, Dout, IRQ, e.dout, e.irq);
                end else begin
                    $display("txn%0d ok: off=%0d dout=%h irq=%b", e.id, Addr[3:2], Dout, IRQ);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int hits[$];
        int r;
        reset = 1'b1; WE = 1'b0; Addr = 30'd0; Din = 32'd0;
        repeat (2) @(posedge clk);
        model_step(1'b1, 1'b0, 2'd0, 32'd0);
        #1;

        // 1: reset state on every offset
        for (int a = 0; a < 4; a++) cycle(1'b0, 1'b0, 2'(a), 32'd0);

        // 2: one-shot, PRESET=5, IM on
        cycle(1'b0, 1'b1, 2'd1, 32'd5);
        cycle(1'b0, 1'b1, 2'd0, 32'h9);
        wait_irq(20, 7, "oneshot_latency");
        idle_reads(3, 2'd0);
        cycle(1'b0, 1'b1, 2'd0, 32'h8);
        idle_reads(3, 2'd2);

        // 3: auto-reload, PRESET=3, period 6
        cycle(1'b0, 1'b1, 2'd1, 32'd3);
        cycle(1'b0, 1'b1, 2'd0, 32'hB);
        for (int i = 1; i <= 30; i++) begin
            cycle(1'b0, 1'b0, 2'd2, 32'd0);
            if (IRQ === 1'b1) hits.push_back(i);
        end
        checks++;
        if (hits.size() < 3) begin
            failures++;
            $display("FAIL reload_pulses: got %0d pulses, expected at least 3", hits.size());
        end else begin
            for (int k = 1; k < hits.size(); k++) begin
                checks++;
                if (hits[k] - hits[k-1] != 6) begin
                    failures++;
                    $display("FAIL reload_period: gap %0d, expected 6", hits[k] - hits[k-1]);
                end else begin
                    $display("reload_period: gap 6 ok");
                end
            end
        end
        cycle(1'b0, 1'b1, 2'd0, 32'h0);
        idle_reads(3, 2'd2);

        // 4: disable mid-count, then restart from a fresh LOAD
        cycle(1'b0, 1'b1, 2'd1, 32'd10);
        cycle(1'b0, 1'b1, 2'd0, 32'h9);
        idle_reads(5, 2'd2);
        cycle(1'b0, 1'b1, 2'd0, 32'h0);
        idle_reads(6, 2'd2);
        cycle(1'b0, 1'b1, 2'd0, 32'h9);
        idle_reads(5, 2'd2);
        cycle(1'b0, 1'b1, 2'd0, 32'h0);
        idle_reads(2, 2'd2);

        // 5: masked interrupt, then ack with IM set
        cycle(1'b0, 1'b1, 2'd1, 32'd2);
        cycle(1'b0, 1'b1, 2'd0, 32'h1);
        idle_reads(8, 2'd2);
        cycle(1'b0, 1'b1, 2'd0, 32'h8);
        idle_reads(3, 2'd0);

        // 6: PRESET=0 behaves as 1; reset mid-count clears everything
        cycle(1'b0, 1'b1, 2'd1, 32'd0);
        cycle(1'b0, 1'b1, 2'd0, 32'h9);
        wait_irq(10, 3, "preset0_latency");
        idle_reads(2, 2'd2);
        cycle(1'b0, 1'b1, 2'd1, 32'd100);
        cycle(1'b0, 1'b1, 2'd0, 32'h9);
        idle_reads(20, 2'd2);
        cycle(1'b1, 1'b0, 2'd2, 32'd0);
        for (int a = 0; a < 4; a++) cycle(1'b0, 1'b0, 2'(a), 32'd0);

        // 7: randomized bus traffic
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2)       cycle(1'b1, 1'b0, 2'($urandom), 32'($urandom));
            else if (r < 12) cycle(1'b0, 1'b1, 2'd0, 32'($urandom));
            else if (r < 19) cycle(1'b0, 1'b1, 2'd1, 32'($urandom_range(0, 9)));
            else if (r < 22) cycle(1'b0, 1'b1, 2'($urandom_range(2, 3)), 32'($urandom));
            else             cycle(1'b0, 1'b0, 2'($urandom), 32'($urandom));
        end

        WE = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
